mole_round_ctrl: RTL and testbench

Game-round controller directly downstream of the LFSR random-number counter in the whack-a-mole design. It requests a random value, reduces it to a mole pattern of at most MAX_MOLES lit LEDs, and shows the pattern for a fixed window. It detects player hits from synchronised slide-switch toggles and keeps score and miss counts over ROUNDS rounds.

---
 rtl/mole_pkg.sv | 48 ++++
 rtl/sw_toggle_sync.sv | 29 ++
 rtl/mole_round_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round controller.
package mole_pkg;

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned VEC_W   = 32;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        REQ,
        SHOW,
        DONE
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Keep only the n lowest-indexed set bits of v.
    function automatic logic [VEC_W-1:0] lowest_n_mask(input logic [VEC_W-1:0] v,
                                                       input int unsigned      n);
        logic [VEC_W-1:0] m;
        int unsigned      taken;
        m     = '0;
        taken = 0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (v[i] && (taken < n)) begin
                m[i]  = 1'b1;
                taken = taken + 1;
            end
        end
        return m;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/sw_toggle_sync.sv
// Per-bit 2-flop synchroniser for raw switches plus toggle detect against a delayed copy.
module sw_toggle_sync #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] toggle_c
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign toggle_c = sync_q ^ prev_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: requests a random value, shows a masked mole
// pattern for a fixed window, and scores switch toggles over a fixed number of rounds.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 18,
    parameter int unsigned MAX_MOLES = 3,
    parameter int unsigned ON_TICKS  = 25000000,
    parameter int unsigned GAP_TICKS = 5000000,
    parameter int unsigned ROUNDS    = 20,
    parameter int unsigned RNG_LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] sw,
    input  logic [NUM_LEDS-1:0] rnd_value,
    output logic                rng_change,
    output logic [NUM_LEDS-1:0] led,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  misses,
    output logic [SCORE_W-1:0]  round_idx,
    output logic                game_over
);

    localparam int unsigned MAX_T0  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned MAX_T   = (MAX_T0 > RNG_LAT + 1) ? MAX_T0 : RNG_LAT + 1;
    localparam int unsigned TIMER_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    state_e               state_q,      state_d;
    logic [TIMER_W-1:0]   timer_q,      timer_d;
    logic [NUM_LEDS-1:0]  led_q,        led_d;
    logic [SCORE_W-1:0]   score_q,      score_d;
    logic [SCORE_W-1:0]   misses_q,     misses_d;
    logic [SCORE_W-1:0]   round_q,      round_d;
    logic                 rng_change_q, rng_change_d;
    logic                 game_over_q,  game_over_d;

    logic [NUM_LEDS-1:0]  toggle;
    logic [NUM_LEDS-1:0]  hits;
    logic [NUM_LEDS-1:0]  wrong;
    logic [NUM_LEDS-1:0]  left;
    logic [NUM_LEDS-1:0]  miss_vec;
    logic                 timeout;

    sw_toggle_sync #(
        .WIDTH (NUM_LEDS)
    ) u_sw_sync (
        .clk      (clk),
        .reset    (reset),
        .sw_i     (sw),
        .toggle_c (toggle)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            led_q        <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            round_q      <= '0;
            rng_change_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            led_q        <= led_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            round_q      <= round_d;
            rng_change_q <= rng_change_d;
            game_over_q  <= game_over_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        led_d        = led_q;
        score_d      = score_q;
        misses_d     = misses_q;
        round_d      = round_q;
        rng_change_d = rng_change_q;
        game_over_d  = game_over_q;
        hits         = toggle & led_q;
        wrong        = toggle & ~led_q;
        left         = led_q & ~hits;
        miss_vec     = wrong;
        timeout      = (timer_q == TIMER_W'(ON_TICKS - 1));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = GAP;
                    timer_d     = '0;
                    led_d       = '0;
                    score_d     = '0;
                    misses_d    = '0;
                    round_d     = '0;
                    game_over_d = 1'b0;
                end
            end
            GAP: begin
                if (timer_q == TIMER_W'(GAP_TICKS - 1)) begin
                    state_d      = REQ;
                    timer_d      = '0;
                    rng_change_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            REQ: begin
                // Value is only trusted on the last cycle of the request window.
                if (timer_q == TIMER_W'(RNG_LAT)) begin
                    state_d      = SHOW;
                    timer_d      = '0;
                    rng_change_d = 1'b0;
                    led_d        = (rnd_value == '0) ? NUM_LEDS'(1)
                                 : NUM_LEDS'(lowest_n_mask(VEC_W'(rnd_value), MAX_MOLES));
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SHOW: begin
                led_d   = left;
                score_d = sat_add(score_q, SCORE_W'(popcount(VEC_W'(hits))));
                if ((left == '0) || timeout) begin
                    // Moles still lit at expiry are disjoint from wrong toggles, so one popcount covers both.
                    if (timeout) begin
                        miss_vec = wrong | left;
                    end
                    led_d   = '0;
                    timer_d = '0;
                    round_d = round_q + SCORE_W'(1);
                    if (round_q == SCORE_W'(ROUNDS - 1)) begin
                        state_d     = DONE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
                misses_d = sat_add(misses_q, SCORE_W'(popcount(VEC_W'(miss_vec))));
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rng_change = rng_change_q;
    assign led        = led_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign round_idx  = round_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomised self-checking bench for mole_round_ctrl against a round-level scoring model.
module tb_mole_round_ctrl;

    localparam int unsigned NL      = 18;
    localparam int          MAXM    = 3;
    localparam int          ON_T    = 8;
    localparam int          GAP_T   = 2;
    localparam int          NROUNDS = 3;
    localparam int          LAT     = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [NL-1:0] sw;
    logic [NL-1:0] rnd_value;
    logic          rng_change;
    logic [NL-1:0] led;
    logic [7:0]    score;
    logic [7:0]    misses;
    logic [7:0]    round_idx;
    logic          game_over;

    int            n_total;
    int            n_bad;
    int            exp_score;
    int            exp_miss;
    int            exp_round;
    logic [NL-1:0] tog [0:5];
    bit            pulse_start;

    mole_round_ctrl #(
        .NUM_LEDS  (NL),
        .MAX_MOLES (MAXM),
        .ON_TICKS  (ON_T),
        .GAP_TICKS (GAP_T),
        .ROUNDS    (NROUNDS),
        .RNG_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sw         (sw),
        .rnd_value  (rnd_value),
        .rng_change (rng_change),
        .led        (led),
        .score      (score),
        .misses     (misses),
        .round_idx  (round_idx),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NL-1:0] model_pattern(input logic [NL-1:0] v);
        int            idx[$];
        logic [NL-1:0] p;
        p = '0;
        for (int i = 0; i < int'(NL); i++) if (v[i]) idx.push_back(i);
        if (idx.size() == 0) return NL'(1);
        for (int k = 0; k < idx.size() && k < MAXM; k++) p[idx[k]] = 1'b1;
        return p;
    endfunction

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic clear_tog();
        for (int j = 0; j < 6; j++) tog[j] = '0;
    endtask

    task automatic random_tog(input logic [NL-1:0] pat);
        for (int j = 0; j < 6; j++) begin
            case ($urandom_range(0, 5))
                0, 1:    tog[j] = '0;
                2:       tog[j] = pat & (NL'(1) << $urandom_range(0, NL - 1));
                3:       tog[j] = NL'(1) << $urandom_range(0, NL - 1);
                4:       tog[j] = pat;
                default: tog[j] = NL'($urandom) & NL'($urandom) & NL'($urandom);
            endcase
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_led"},   32'(led),        0);
        check({tag, "_score"}, 32'(score),      0);
        check({tag, "_miss"},  32'(misses),     0);
        check({tag, "_round"}, 32'(round_idx),  0);
        check({tag, "_rng"},   32'(rng_change), 0);
        check({tag, "_over"},  32'(game_over),  0);
    endtask

    // Called at a negedge from IDLE or DONE.
    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_score = 0;
        exp_miss  = 0;
        exp_round = 0;
        check("clr_score", 32'(score),     0);
        check("clr_miss",  32'(misses),    0);
        check("clr_round", 32'(round_idx), 0);
        check("clr_over",  32'(game_over), 0);
    endtask

    // Plays one round with the toggle plan in tog[]; toggles driven j cycles into SHOW land 2 cycles later.
    task automatic play_round(input logic [NL-1:0] rv);
        int            waits;
        int            highs;
        int            exit_k;
        int            sample_j;
        logic [NL-1:0] pat;
        logic [NL-1:0] rem;
        logic [NL-1:0] hit;
        pat    = model_pattern(rv);
        rem    = pat;
        exit_k = -1;
        for (int j = 0; j < 6; j++) begin
            if (exit_k < 0 && tog[j] != '0) begin
                hit        = tog[j] & rem;
                exp_score += $countones(hit);
                exp_miss  += $countones(tog[j] & ~rem);
                rem        = rem & ~hit;
                if (rem == '0) exit_k = j + 2;
            end
        end
        if (exit_k < 0) begin
            exp_miss += $countones(rem);
            sample_j  = ON_T;
        end else begin
            sample_j  = exit_k + 1;
        end
        exp_round++;

        waits = 0;
        while (!rng_change && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("gap_len", 32'(waits), 32'(GAP_T));
        highs = 0;
        while (rng_change && highs < 20) begin
            highs++;
            rnd_value = (highs == LAT + 1) ? rv : NL'($urandom);
            @(negedge clk);
        end
        check("rng_len", 32'(highs), 32'(LAT + 1));
        check("pattern", 32'(led), 32'(pat));

        for (int j = 0; j <= ON_T; j++) begin
            if (j == sample_j) break;
            if (j < 6) sw = sw ^ tog[j];
            start = pulse_start && (j == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("led_end", 32'(led),       0);
        check("score",   32'(score),     32'(sat8(exp_score)));
        check("misses",  32'(misses),    32'(sat8(exp_miss)));
        check("round",   32'(round_idx), 32'(exp_round));
        check("over",    32'(game_over), 32'(exp_round == NROUNDS));
    endtask

    initial begin
        logic [NL-1:0] rv;
        logic [NL-1:0] pat;
        bit            seen;
        n_total     = 0;
        n_bad       = 0;
        exp_score   = 0;
        exp_miss    = 0;
        exp_round   = 0;
        pulse_start = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        sw          = '0;
        rnd_value   = '0;
        clear_tog();
        #1 reset = 1'b0;

        // Reset held with switches moving.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sw = NL'($urandom);
        end
        check_outputs_zero("rst");

        // Released, no start: must stay idle.
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= rng_change;
            sw = sw ^ NL'($urandom);
        end
        repeat (4) @(negedge clk);
        check("idle_no_req", 32'(seen), 0);
        check_outputs_zero("idle");

        // Directed game: full hit, zero value, timeout with a wrong toggle.
        start_game();
        clear_tog();
        tog[0] = 18'h00016;
        play_round(18'h000F6);
        clear_tog();
        play_round(18'h00000);
        clear_tog();
        tog[1] = 18'h00004;
        tog[3] = 18'h00200;
        play_round(18'h000F6);

        // Toggles in DONE are ignored.
        for (int i = 0; i < 4; i++) begin
            sw = sw ^ NL'($urandom);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("done_miss",  32'(misses),    32'(exp_miss));
        check("done_score", 32'(score),     32'(exp_score));
        check("done_over",  32'(game_over), 1);
        check("done_led",   32'(led),       0);

        // Random games.
        for (int g = 0; g < 5; g++) begin
            start_game();
            for (int r = 0; r < NROUNDS; r++) begin
                case ($urandom_range(0, 3))
                    0:       rv = '0;
                    1:       rv = NL'($urandom) & NL'($urandom) & NL'($urandom);
                    default: rv = NL'($urandom);
                endcase
                pat         = model_pattern(rv);
                pulse_start = ($urandom_range(0, 3) == 0);
                random_tog(pat);
                play_round(rv);
            end
        end
        pulse_start = 1'b0;

        // Wrong-toggle storm drives misses into saturation.
        start_game();
        for (int r = 0; r < NROUNDS; r++) begin
            rv  = NL'($urandom);
            pat = model_pattern(rv);
            for (int j = 0; j < 6; j++) tog[j] = ~pat;
            play_round(rv);
        end

        // Reset during SHOW after some score has accumulated.
        start_game();
        clear_tog();
        tog[0] = 18'h00016;
        play_round(18'h000F6);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rng_change) seen = 1'b1;
        end
        for (int i = 0; i < 10 && rng_change; i++) @(negedge clk);
        @(negedge clk);
        check("pre_rst_score", 32'(score), 3);
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_show");
        @(negedge clk);
        reset = 1'b1;

        // Reset during the RNG request drops it at once.
        start_game();
        for (int i = 0; i < 20 && !rng_change; i++) @(negedge clk);
        check("req_seen", 32'(rng_change), 1);
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_req");
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= rng_change;
        end
        check("post_rst_idle", 32'(seen), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
